// File: rtl/hilo_muldiv.sv
// Multi-cycle MULT/MULTU/DIV/DIVU engine plus the architectural HI/LO pair.
// Define HILO_ITER_MUL_EN to run multiplies on the shared 32-step shift-add path instead of a 32x32 multiplier.
module hilo_muldiv (
  input  logic        clk,
  input  logic        rst,
  input  logic        startE,
  input  logic [1:0]  opE,
  input  logic [31:0] srcaE,
  input  logic [31:0] srcbE,
  input  logic        flushE,
  input  logic        stall_ext,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] hi_res,
  output logic [31:0] lo_res,
  input  logic        MulDivW,
  input  logic [31:0] hiW,
  input  logic [31:0] loW,
  input  logic        WriteHiLoW,
  input  logic        HiorLoW,
  input  logic [31:0] wdataW,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [31:0] r_acc, r_q, r_b, r_a_orig;
  logic        r_is_div, r_neg_q, r_neg_r, r_div0;
  logic [31:0] r_hi, r_lo;

  logic        w_signed, w_a_neg, w_b_neg, w_start;
  logic [31:0] w_a_mag, w_b_mag;
  logic [33:0] w_trial;
  logic [63:0] w_prod_neg;

  assign w_signed = ~opE[0];
  assign w_a_neg  = w_signed & srcaE[31];
  assign w_b_neg  = w_signed & srcbE[31];
  assign w_a_mag  = w_a_neg ? (32'd0 - srcaE) : srcaE;
  assign w_b_mag  = w_b_neg ? (32'd0 - srcbE) : srcbE;
  assign w_start  = startE & ~flushE;

  // Restoring division: trial-subtract the divisor from the shifted partial remainder.
  assign w_trial    = {1'b0, r_acc, r_q[31]} - {2'b00, r_b};
  assign w_prod_neg = 64'd0 - {r_acc, r_q};

`ifdef HILO_ITER_MUL_EN
  logic [32:0] w_mul_sum;
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : 33'd0);
`else
  logic [63:0] w_prod;
  assign w_prod = {{32{w_a_neg}}, srcaE} * {{32{w_b_neg}}, srcbE};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_acc    <= 32'd0;
      r_q      <= 32'd0;
      r_b      <= 32'd0;
      r_a_orig <= 32'd0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_a_orig <= srcaE;
            r_b      <= w_b_mag;
            r_cnt    <= 5'd0;
            r_is_div <= opE[1];
            r_div0   <= opE[1] & (srcbE == 32'd0);
            if (opE[1]) begin
              r_acc   <= 32'd0;
              r_q     <= w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_state <= S_BUSY;
            end else begin
`ifdef HILO_ITER_MUL_EN
              r_acc   <= 32'd0;
              r_q     <= w_a_mag;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= 1'b0;
              r_state <= S_BUSY;
`else
              {r_acc, r_q} <= w_prod;
              r_neg_q <= 1'b0;
              r_neg_r <= 1'b0;
              r_state <= S_DONE;
`endif
            end
          end
        end
        S_BUSY: begin
          if (flushE) begin
            r_state <= S_IDLE;
          end else begin
`ifdef HILO_ITER_MUL_EN
            if (!r_is_div) begin
              r_acc <= w_mul_sum[32:1];
              r_q   <= {w_mul_sum[0], r_q[31:1]};
            end else
`endif
            begin
              if (!w_trial[33]) begin
                r_acc <= w_trial[31:0];
                r_q   <= {r_q[30:0], 1'b1};
              end else begin
                r_acc <= {r_acc[30:0], r_q[31]};
                r_q   <= {r_q[30:0], 1'b0};
              end
            end
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) r_state <= S_DONE;
          end
        end
        S_DONE: begin
          if (flushE || !stall_ext) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Sign correction is applied on the fly; operand registers hold still while in DONE.
  always_comb begin
    hi_res = r_acc;
    lo_res = r_q;
    if (r_div0) begin
      hi_res = r_a_orig;
      lo_res = 32'hFFFF_FFFF;
    end else if (r_is_div) begin
      hi_res = r_neg_r ? (32'd0 - r_acc) : r_acc;
      lo_res = r_neg_q ? (32'd0 - r_q) : r_q;
    end else if (r_neg_q) begin
      {hi_res, lo_res} = w_prod_neg;
    end
  end

  assign stall_o = (w_start & (r_state != S_DONE)) | (r_state == S_BUSY);
  assign done_o  = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= 32'd0;
      r_lo <= 32'd0;
    end else if (MulDivW) begin
      r_hi <= hiW;
      r_lo <= loW;
    end else if (WriteHiLoW) begin
      if (HiorLoW) r_hi <= wdataW;
      else         r_lo <= wdataW;
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv; multiply latency follows HILO_ITER_MUL_EN.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst, startE, flushE, stall_ext;
  logic [1:0]  opE;
  logic [31:0] srcaE, srcbE;
  logic        stall_o, done_o;
  logic [31:0] hi_res, lo_res;
  logic        MulDivW, WriteHiLoW, HiorLoW;
  logic [31:0] hiW, loW, wdataW, hi_o, lo_o;

  int total = 0;
  int bad   = 0;

`ifdef HILO_ITER_MUL_EN
  localparam int MUL_STALL = 33;
`else
  localparam int MUL_STALL = 1;
`endif

  always #5 clk = ~clk;

  hilo_muldiv dut (
    .clk(clk), .rst(rst), .startE(startE), .opE(opE), .srcaE(srcaE), .srcbE(srcbE),
    .flushE(flushE), .stall_ext(stall_ext), .stall_o(stall_o), .done_o(done_o),
    .hi_res(hi_res), .lo_res(lo_res), .MulDivW(MulDivW), .hiW(hiW), .loW(loW),
    .WriteHiLoW(WriteHiLoW), .HiorLoW(HiorLoW), .wdataW(wdataW), .hi_o(hi_o), .lo_o(lo_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Holds startE through the done cycle, as E would; hold = DONE cycles with stall_ext high.
  task automatic run_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_stall, input logic [31:0] eh,
                        input logic [31:0] el, input int hold);
    int n_stall;
    bit got;
    n_stall = 0;
    got = 1'b0;
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    stall_ext = (hold > 0);
    for (int i = 0; i < 100 && !got; i++) begin
      #2;
      if (done_o) got = 1'b1;
      else begin
        if (stall_o) n_stall++;
        next_cycle();
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_stall_cycles"}, 32'(n_stall), 32'(exp_stall));
    chk({tag, "_hi"}, hi_res, eh);
    chk({tag, "_lo"}, lo_res, el);
    chk({tag, "_stall_in_done"}, 32'(stall_o), 32'd0);
    for (int k = 0; k < hold; k++) begin
      next_cycle();
      if (k == hold - 1) stall_ext = 1'b0;
      #2;
      chk({tag, "_held_done"}, 32'(done_o), 32'd1);
      chk({tag, "_held_hi"}, hi_res, eh);
      chk({tag, "_held_lo"}, lo_res, el);
      chk({tag, "_held_stall"}, 32'(stall_o), 32'd0);
    end
    stall_ext = 1'b0;
    next_cycle();
    startE = 1'b0;
    #2;
    chk({tag, "_done_drops"}, 32'(done_o), 32'd0);
    chk({tag, "_idle_after"}, 32'(stall_o), 32'd0);
  endtask

  initial begin
    int seen_done;
    rst = 1'b1; startE = 1'b0; flushE = 1'b0; stall_ext = 1'b0; opE = 2'b00;
    srcaE = 32'd0; srcbE = 32'd0; MulDivW = 1'b0; WriteHiLoW = 1'b0; HiorLoW = 1'b0;
    hiW = 32'd0; loW = 32'd0; wdataW = 32'd0;
    next_cycle();
    next_cycle();
    #2;
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_hi_res", hi_res, 32'd0);
    chk("rst_lo_res", lo_res, 32'd0);
    chk("rst_hi_o", hi_o, 32'd0);
    chk("rst_lo_o", lo_o, 32'd0);
    rst = 1'b0;
    next_cycle();

    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 0);
    run_op("div_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("div_5_0", 2'b10, 32'd5, 32'd0, 33, 32'd5, 32'hFFFF_FFFF, 0);
    run_op("divu_7_m1", 2'b11, 32'd7, 32'hFFFF_FFFF, 33, 32'd7, 32'd0, 0);
    run_op("mult_m1_3", 2'b00, 32'hFFFF_FFFF, 32'd3, MUL_STALL, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 0);
    run_op("multu_m1_3", 2'b01, 32'hFFFF_FFFF, 32'd3, MUL_STALL, 32'd2, 32'hFFFF_FFFD, 0);

    // Flush a divide in its tenth cycle; it must never strobe done.
    startE = 1'b1; opE = 2'b11; srcaE = 32'd1000; srcbE = 32'd3;
    for (int i = 0; i < 10; i++) next_cycle();
    flushE = 1'b1; startE = 1'b0;
    #2;
    chk("flush_no_done_now", 32'(done_o), 32'd0);
    next_cycle();
    flushE = 1'b0;
    #2;
    chk("flush_idle_next", 32'(stall_o), 32'd0);
    seen_done = 0;
    for (int i = 0; i < 40; i++) begin
      next_cycle();
      if (done_o) seen_done++;
    end
    chk("flush_never_done", 32'(seen_done), 32'd0);
    run_op("multu_6_7", 2'b01, 32'd6, 32'd7, MUL_STALL, 32'd0, 32'd42, 0);

    run_op("divu_hold", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14, 3);

    MulDivW = 1'b1; hiW = 32'd1; loW = 32'd2;
    WriteHiLoW = 1'b1; HiorLoW = 1'b1; wdataW = 32'd9;
    next_cycle();
    MulDivW = 1'b0; WriteHiLoW = 1'b0;
    #2;
    chk("prio_hi", hi_o, 32'd1);
    chk("prio_lo", lo_o, 32'd2);
    WriteHiLoW = 1'b1; HiorLoW = 1'b0; wdataW = 32'd55;
    next_cycle();
    HiorLoW = 1'b1; wdataW = 32'd77;
    #2;
    chk("mtlo_lo", lo_o, 32'd55);
    chk("mtlo_hi_kept", hi_o, 32'd1);
    next_cycle();
    WriteHiLoW = 1'b0;
    #2;
    chk("mthi_hi", hi_o, 32'd77);
    chk("mthi_lo_kept", lo_o, 32'd55);

    // Reset in the middle of a divide discards it.
    startE = 1'b1; opE = 2'b11; srcaE = 32'd100; srcbE = 32'd7;
    for (int i = 0; i < 5; i++) next_cycle();
    rst = 1'b1; startE = 1'b0;
    next_cycle();
    #2;
    chk("midrst_stall", 32'(stall_o), 32'd0);
    chk("midrst_done", 32'(done_o), 32'd0);
    chk("midrst_hi_o", hi_o, 32'd0);
    chk("midrst_lo_o", lo_o, 32'd0);
    chk("midrst_lo_res", lo_res, 32'd0);
    rst = 1'b0;
    next_cycle();
    run_op("div_after_rst", 2'b10, 32'd20, 32'hFFFF_FFFA, 33, 32'd2, 32'hFFFF_FFFD, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
